// File: rtl/par_moody_source.sv
// rtl/par_moody_source.sv - synthetic NoC traffic source with LFSR injection, backlog FIFO and statistics
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module par_moody_source #(
    parameter int          id       = -1,
    parameter int          activity = 0,
    parameter int          QDEPTH   = 4,
    parameter int          MAX_PKTS = 0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 channel_busy,
    output logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0]  item_out,
    output logic                                 valid,
    output logic [15:0]                          tx_count,
    output logic [15:0]                          drop_count,
    output logic                                 done
);
    localparam int PW = `PAYLOAD_SIZE;
    localparam int AB = `ADDR_BITS;
    localparam int W  = PW + AB;
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;

    logic [15:0]   lfsr_q, lfsr_d;
    logic [PW-1:0] seq_q, seq_d;
    logic [31:0]   created_q, created_d;
    logic [W-1:0]  mem_q [QDEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   tx_q, tx_d, drop_q, drop_d;
    logic          done_q, done_d;

    logic          quota_ok, rate_hit, create, pop, push, full;
    logic [AB-1:0] dest_raw, dest;
    logic [W-1:0]  new_item;

    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        quota_ok = (MAX_PKTS == 0) || (created_q < 32'(MAX_PKTS));
        rate_hit = (activity >= 255) || ({24'b0, lfsr_q[7:0]} < 32'(activity));
        create   = enable && quota_ok && rate_hit;

        // Never address ourselves: bump to the next node instead.
        dest_raw = lfsr_q[AB+7:8];
        dest     = dest_raw;
        if ((id >= 0) && ({{(32-AB){1'b0}}, dest_raw} == 32'(id)))
            dest = dest_raw + AB'(1);
        new_item = {seq_q, dest};

        full = (count_q == CW'(QDEPTH));
        pop  = (count_q != '0) && !channel_busy;
        push = create && (!full || pop);

        seq_d     = create ? seq_q + PW'(1) : seq_q;
        created_d = create ? created_q + 32'd1 : created_q;
        wr_d      = push ? ((wr_q == AW'(QDEPTH - 1)) ? '0 : wr_q + AW'(1)) : wr_q;
        rd_d      = pop  ? ((rd_q == AW'(QDEPTH - 1)) ? '0 : rd_q + AW'(1)) : rd_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        tx_d      = pop ? tx_q + 16'd1 : tx_q;
        drop_d    = (create && !push) ? drop_q + 16'd1 : drop_q;
        done_d    = done_q || ((MAX_PKTS > 0) && (created_d == 32'(MAX_PKTS)) && (count_d == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q    <= LFSR_INIT;
            seq_q     <= '0;
            created_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            tx_q      <= '0;
            drop_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            seq_q     <= seq_d;
            created_q <= created_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            tx_q      <= tx_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem_q[wr_q] <= new_item;
    end

    // Outputs come only from registered state, so channel_busy never reaches them combinationally.
    assign valid      = (count_q != '0);
    assign item_out   = valid ? mem_q[rd_q] : '0;
    assign tx_count   = tx_q;
    assign drop_count = drop_q;
    assign done       = done_q;
endmodule
